// File: rtl/otter_branch_predictor.sv
// ============================================================================
//  Module   : otter_branch_predictor
//  Purpose  : Direct-mapped branch target buffer with 2-bit saturating
//             direction counters for the pipelined OTTER core. Fetch gets a
//             same-cycle predicted next PC. Execute feeds back resolved
//             control-flow instructions to train the table, raise
//             mispredict flushes and supply the redirect PC.
//  Ports    : CLK, RESET (async, active-high), bp_flush (invalidate all)
//             if_pc -> if_pred_taken / if_pred_pc          (lookup)
//             ex_upd_* , ex_pred_* -> ex_mispredict / ex_redirect_pc
//             stat_branches / stat_mispredicts             (statistics)
//  Options  : OTTER_BP_STATS_EN builds the two saturating statistics
//             counters. Without it both stat ports read 0 and no counter
//             flops exist.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_branch_predictor #(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] INIT_CTR = 2'b10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        bp_flush,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_pc,
    input  logic        ex_upd_valid,
    input  logic [31:0] ex_upd_pc,
    input  logic        ex_upd_is_jump,
    input  logic        ex_upd_taken,
    input  logic [31:0] ex_upd_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_pc,
    output logic        ex_mispredict,
    output logic [31:0] ex_redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // BTB storage, read asynchronously
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic             jump_q   [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;

    assign w_if_idx      = if_pc[IDX_W+1:2];
    assign w_if_tag      = if_pc[31:IDX_W+2];
    assign w_if_hit      = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
    assign if_pred_taken = w_if_hit && (jump_q[w_if_idx] || ctr_q[w_if_idx][1]);
    assign if_pred_pc    = if_pred_taken ? target_q[w_if_idx] : (if_pc + 32'd4);

    // ------------------------------------------------------------------
    // Execute-stage resolution
    // ------------------------------------------------------------------
    assign ex_mispredict  = ex_upd_valid &&
                            ((ex_upd_taken != ex_pred_taken) ||
                             (ex_upd_taken && (ex_upd_target != ex_pred_pc)));
    assign ex_redirect_pc = ex_upd_taken ? ex_upd_target : (ex_upd_pc + 32'd4);

    // ------------------------------------------------------------------
    // Training: compute the new contents of the single indexed entry
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             upd_we_d;
    logic [31:0]      upd_target_d;
    logic [1:0]       upd_ctr_d;
    logic             upd_jump_d;

    assign w_upd_idx = ex_upd_pc[IDX_W+1:2];
    assign w_upd_tag = ex_upd_pc[31:IDX_W+2];
    assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);

    always_comb begin
        upd_we_d     = 1'b0;
        upd_target_d = target_q[w_upd_idx];
        upd_ctr_d    = ctr_q[w_upd_idx];
        upd_jump_d   = jump_q[w_upd_idx];
        if (ex_upd_valid) begin
            if (w_upd_hit) begin
                upd_we_d = 1'b1;
                if (ex_upd_is_jump) begin
                    upd_ctr_d    = 2'd3;
                    upd_target_d = ex_upd_target;
                end else if (ex_upd_taken) begin
                    upd_ctr_d    = (ctr_q[w_upd_idx] == 2'd3) ? 2'd3 : ctr_q[w_upd_idx] + 2'd1;
                    upd_target_d = ex_upd_target;
                end else begin
                    upd_ctr_d    = (ctr_q[w_upd_idx] == 2'd0) ? 2'd0 : ctr_q[w_upd_idx] - 2'd1;
                end
            end else if (ex_upd_taken) begin
                // Allocate over whatever occupies the slot
                upd_we_d     = 1'b1;
                upd_target_d = ex_upd_target;
                upd_jump_d   = ex_upd_is_jump;
                upd_ctr_d    = ex_upd_is_jump ? 2'd3 : INIT_CTR;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
                jump_q[i]   <= 1'b0;
            end
        end else if (bp_flush) begin
            // Flush wins over a coincident update
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_we_d) begin
            valid_q[w_upd_idx]  <= 1'b1;
            tag_q[w_upd_idx]    <= w_upd_tag;
            target_q[w_upd_idx] <= upd_target_d;
            ctr_q[w_upd_idx]    <= upd_ctr_d;
            jump_q[w_upd_idx]   <= upd_jump_d;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef OTTER_BP_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    // Counters saturate and ignore bp_flush
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (ex_upd_valid && (stat_br_q != 32'hFFFF_FFFF)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (ex_mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_otter_branch_predictor.sv
// ============================================================================
//  Module   : tb_otter_branch_predictor
//  Purpose  : Self-checking bench for otter_branch_predictor. A table-level
//             model of the BTB predicts every output each cycle; directed
//             literal checks pin the model on the documented scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_otter_branch_predictor;

    localparam int ENTRIES = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        bp_flush;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_pc;
    logic        ex_upd_valid;
    logic [31:0] ex_upd_pc;
    logic        ex_upd_is_jump;
    logic        ex_upd_taken;
    logic [31:0] ex_upd_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_pc;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 CLK = ~CLK;

    otter_branch_predictor #(.ENTRIES(ENTRIES), .INIT_CTR(2'b10)) dut (
        .CLK(CLK), .RESET(RESET), .bp_flush(bp_flush),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_pc(if_pred_pc),
        .ex_upd_valid(ex_upd_valid), .ex_upd_pc(ex_upd_pc),
        .ex_upd_is_jump(ex_upd_is_jump), .ex_upd_taken(ex_upd_taken),
        .ex_upd_target(ex_upd_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_pc(ex_pred_pc), .ex_mispredict(ex_mispredict),
        .ex_redirect_pc(ex_redirect_pc), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_jump  [ENTRIES];
    longint      m_br;
    longint      m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        int unsigned p = pc;
        return int'((p / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        int unsigned p = pc;
        return p / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_jump[idx_of(pc)] || (m_ctr[idx_of(pc)] >= 2));
    endfunction

    function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        if (!ex_upd_valid) return 1'b0;
        if (ex_upd_taken != ex_pred_taken) return 1'b1;
        return ex_upd_taken && (ex_upd_target != ex_pred_pc);
    endfunction

    always @(posedge CLK or posedge RESET) begin : model_update
        int i;
        bit hit;
        if (RESET) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
                m_jump[k]  = 1'b0;
                m_tag[k]   = 0;
                m_tgt[k]   = 32'd0;
            end
            m_br = 0;
            m_mp = 0;
        end else begin
            if (ex_upd_valid && m_br < 64'hFFFF_FFFF) m_br++;
            if (m_mispredict() && m_mp < 64'hFFFF_FFFF) m_mp++;
            if (bp_flush) begin
                for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
            end else if (ex_upd_valid) begin
                i   = idx_of(ex_upd_pc);
                hit = m_hit(ex_upd_pc);
                if (hit && ex_upd_is_jump) begin
                    m_ctr[i] = 3;
                    m_tgt[i] = ex_upd_target;
                end else if (hit) begin
                    if (ex_upd_taken) begin
                        if (m_ctr[i] < 3) m_ctr[i]++;
                        m_tgt[i] = ex_upd_target;
                    end else if (m_ctr[i] > 0) begin
                        m_ctr[i]--;
                    end
                end else if (ex_upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(ex_upd_pc);
                    m_tgt[i]   = ex_upd_target;
                    m_jump[i]  = ex_upd_is_jump;
                    m_ctr[i]   = ex_upd_is_jump ? 3 : 2;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_pred_taken(if_pc)});
            chk("if_pred_pc", if_pred_pc, m_pred_pc(if_pc));
            chk("ex_mispredict", {31'd0, ex_mispredict}, {31'd0, m_mispredict()});
            if (ex_upd_valid)
                chk("ex_redirect_pc", ex_redirect_pc,
                    ex_upd_taken ? ex_upd_target : ex_upd_pc + 32'd4);
`ifdef OTTER_BP_STATS_EN
            chk("stat_branches", stat_branches, m_br[31:0]);
            chk("stat_mispredicts", stat_mispredicts, m_mp[31:0]);
`else
            chk("stat_branches", stat_branches, 32'd0);
            chk("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        ex_upd_valid   = 1'b0;
        ex_upd_pc      = 32'd0;
        ex_upd_is_jump = 1'b0;
        ex_upd_taken   = 1'b0;
        ex_upd_target  = 32'd0;
        ex_pred_taken  = 1'b0;
        ex_pred_pc     = 32'd0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc);
        ex_upd_valid   = 1'b1;
        ex_upd_pc      = pc;
        ex_upd_is_jump = jmp;
        ex_upd_taken   = tk;
        ex_upd_target  = tgt;
        ex_pred_taken  = ptk;
        ex_pred_pc     = ppc;
    endtask

    task automatic mid();
        @(negedge CLK);
        #1;
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rnd_pc();
        return 32'h1000 + 32'($urandom_range(0, 3) << 6) + 32'($urandom_range(0, 15) << 2);
    endfunction

    function automatic logic [31:0] rnd_tgt();
        case ($urandom_range(0, 3))
            0:       return 32'h200;
            1:       return 32'h300;
            2:       return 32'h400;
            default: return {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        RESET    = 1'b1;
        bp_flush = 1'b0;
        if_pc    = 32'h100;
        idle();
        #22;
        RESET = 1'b0;
        nxt();
        chk_en = 1'b1;

        // Reset state
        mid();
        chk("reset pred_taken", {31'd0, if_pred_taken}, 32'd0);
        chk("reset pred_pc", if_pred_pc, 32'h104);
        chk("reset stat_branches", stat_branches, 32'd0);

        // Not-taken miss: no mispredict, no allocation
        nxt(); upd(32'h40, 0, 0, 32'h0, 0, 32'h44); if_pc = 32'h40; mid();
        chk("nt mispredict", {31'd0, ex_mispredict}, 32'd0);
        chk("nt redirect", ex_redirect_pc, 32'h44);
        nxt(); idle(); mid();
        chk("nt no alloc", {31'd0, if_pred_taken}, 32'd0);

        // Taken miss allocates; same-cycle lookup still sees old entry
        nxt(); upd(32'h40, 0, 1, 32'h200, 0, 32'h44); mid();
        chk("alloc mispredict", {31'd0, ex_mispredict}, 32'd1);
        chk("alloc redirect", ex_redirect_pc, 32'h200);
        chk("alloc same-cycle", {31'd0, if_pred_taken}, 32'd0);
        nxt(); idle(); mid();
        chk("alloc hit taken", {31'd0, if_pred_taken}, 32'd1);
        chk("alloc hit pc", if_pred_pc, 32'h200);

        // Two not-taken -> ctr 0
        nxt(); upd(32'h40, 0, 0, 32'h0, 1, 32'h200); mid();
        nxt(); upd(32'h40, 0, 0, 32'h0, 1, 32'h200); mid();
        nxt(); idle(); mid();
        chk("ctr0 pred_pc", if_pred_pc, 32'h44);

        // Four taken saturate at 3; one not-taken keeps taken; second drops
        for (int k = 0; k < 4; k++) begin
            nxt(); upd(32'h40, 0, 1, 32'h200, 1, 32'h200); mid();
        end
        nxt(); upd(32'h40, 0, 0, 32'h0, 1, 32'h200); mid();
        nxt(); idle(); mid();
        chk("sat ctr2 taken", {31'd0, if_pred_taken}, 32'd1);
        chk("sat ctr2 pc", if_pred_pc, 32'h200);
        nxt(); upd(32'h40, 0, 0, 32'h0, 1, 32'h200); mid();
        nxt(); idle(); mid();
        chk("sat ctr1 not taken", {31'd0, if_pred_taken}, 32'd0);

        // Aliasing at the same index
        nxt(); upd(32'h80, 0, 1, 32'h300, 0, 32'h84); if_pc = 32'h80; mid();
        chk("alias same-cycle", {31'd0, if_pred_taken}, 32'd0);
        nxt(); idle(); if_pc = 32'h40; mid();
        chk("alias 0x40 miss", if_pred_pc, 32'h44);
        nxt(); if_pc = 32'h80; mid();
        chk("alias 0x80 hit", if_pred_pc, 32'h300);

        // JAL with wrong predicted target
        nxt(); upd(32'h80, 1, 1, 32'h400, 1, 32'h300); mid();
        chk("jal mispredict", {31'd0, ex_mispredict}, 32'd1);
        chk("jal redirect", ex_redirect_pc, 32'h400);
        chk("jal same-cycle old", if_pred_pc, 32'h300);
        nxt(); idle(); mid();
        chk("jal new target", if_pred_pc, 32'h400);

        // PC+4 wrap
        nxt(); if_pc = 32'hFFFF_FFFC; mid();
        chk("wrap pred_pc", if_pred_pc, 32'h0);

        // Flush beats a concurrent update
        nxt(); upd(32'h40, 0, 1, 32'h500, 0, 32'h44); bp_flush = 1'b1; mid();
        nxt(); bp_flush = 1'b0; idle(); if_pc = 32'h40; mid();
        chk("flush 0x40 miss", {31'd0, if_pred_taken}, 32'd0);
        nxt(); if_pc = 32'h80; mid();
        chk("flush 0x80 miss", {31'd0, if_pred_taken}, 32'd0);

        // Asynchronous reset between edges
        nxt(); upd(32'h80, 1, 1, 32'h600, 0, 32'h84); mid();
        nxt(); idle(); mid();
        chk("pre-reset hit", {31'd0, if_pred_taken}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("async reset taken", {31'd0, if_pred_taken}, 32'd0);
        chk("async reset pc", if_pred_pc, 32'h84);
        #1;
        RESET = 1'b0;

        // Statistics: 10 updates, 3 mispredicts, then a flush
        nxt();
        for (int k = 0; k < 10; k++) begin
            upd(32'h40, 0, 0, 32'h0, (k % 4 == 0), 32'h44); mid(); nxt();
        end
        idle(); mid();
`ifdef OTTER_BP_STATS_EN
        chk("stats branches", stat_branches, 32'd10);
        chk("stats mispredicts", stat_mispredicts, 32'd3);
`else
        chk("stats branches off", stat_branches, 32'd0);
        chk("stats mispredicts off", stat_mispredicts, 32'd0);
`endif
        nxt(); bp_flush = 1'b1; mid();
        nxt(); bp_flush = 1'b0; mid();
`ifdef OTTER_BP_STATS_EN
        chk("stats after flush br", stat_branches, 32'd10);
        chk("stats after flush mp", stat_mispredicts, 32'd3);
`else
        chk("stats after flush br off", stat_branches, 32'd0);
        chk("stats after flush mp off", stat_mispredicts, 32'd0);
`endif

        // Randomized traffic against the model
        nxt();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = rnd_pc();
            if ($urandom_range(0, 7) == 0) begin
                idle();
            end else begin
                upd(pc, ($urandom_range(0, 4) == 0), $urandom_range(0, 1) != 0,
                    rnd_tgt(), 1'b0, 32'd0);
                if ($urandom_range(0, 1) != 0) begin
                    ex_pred_taken = m_pred_taken(pc);
                    ex_pred_pc    = m_pred_pc(pc);
                end else begin
                    ex_pred_taken = $urandom_range(0, 1) != 0;
                    ex_pred_pc    = ex_pred_taken ? rnd_tgt() : pc + 32'd4;
                end
                if (ex_upd_is_jump) ex_upd_taken = 1'b1;
            end
            if_pc    = ($urandom_range(0, 1) != 0) ? pc : rnd_pc();
            bp_flush = ($urandom_range(0, 63) == 0);
            nxt();
        end
        bp_flush = 1'b0;
        idle();
        mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
